// File: rtl/ramsp_ctrl.sv
// rtl/ramsp_ctrl.sv - single-port synchronous RAM initiator with credit-based read response FIFO
//
// Accepts a valid/ready stream of read and write commands. It drives the RAM port
// combinationally from the command port. It captures the registered read data one
// cycle after issue and returns it on a valid/ready response stream. The response
// stream is fed from a DEPTH-entry FIFO.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_write            1 = write, 0 = read
//   cmd_addr, cmd_wdata  command address / write data
//   rsp_valid/rsp_ready  read response handshake
//   rsp_rdata            read data at FIFO head
//   mem_we, mem_addr     RAM write enable / address
//   mem_din, mem_dout    RAM write data / registered read data
module ramsp_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rd_pend_q;
    logic          rd_pend_d;
    logic [CW-1:0] outstanding;
    logic          cmd_fire;
    logic          push;
    logic          pop;

    // Every accepted read owns one FIFO slot from issue until it is popped.
    // The slot is counted in rd_pend while the read is in flight, and in cnt once
    // the data is captured. This guarantees a slot is free when the data arrives.
    assign outstanding = cnt_q + CW'(rd_pend_q);
    assign cmd_ready   = nreset & (outstanding < DEPTH_C);

    assign cmd_fire = cmd_valid & cmd_ready;
    assign mem_we   = cmd_fire & cmd_write;
    assign mem_addr = cmd_addr;
    assign mem_din  = cmd_wdata;

    assign rsp_valid = (cnt_q != '0);
    assign rsp_rdata = fifo_q[rd_ptr_q];

    // The RAM output is valid exactly in the cycle after a read issue.
    assign push      = rd_pend_q;
    assign pop       = rsp_valid & rsp_ready;
    assign rd_pend_d = cmd_fire & ~cmd_write;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            cnt_q     <= cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_dout;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule

// File: doc/ramsp_ctrl.md
Name: ramsp_ctrl

Overview:
- Initiator-side controller for a single-port synchronous RAM with one-cycle registered read latency and read-first behaviour.
- Accepts a valid/ready command stream of reads and writes, drives the RAM port, and captures read data exactly one cycle after issue.
- Returns read data on a valid/ready response stream through an internal response FIFO.
- Uses credit-based flow control, so read data is never lost when the response consumer stalls.

Parameters:
- DW, 16, data width in bits.
- AW, 10, address width in bits.
- DEPTH, 4, response FIFO entries; power of 2, minimum 2. DEPTH>=3 is required for full-rate reads.

Ports:
- clk  input  1  clock.
- nreset  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  AW  command address.
- cmd_wdata  input  DW  write data; ignored for reads.
- rsp_valid  output  1  read response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DW  read data, FIFO head.
- mem_we  output  1  RAM write enable.
- mem_addr  output  AW  RAM address.
- mem_din  output  DW  RAM write data.
- mem_dout  input  DW  RAM registered read data.

Behaviour:
- Reset (nreset low, asynchronous):
  - FIFO empty, pointers 0, rd_pend=0, rsp_valid=0, rsp_rdata=0.
  - cmd_ready=0 while nreset is low.
  - A read in flight at reset is discarded.
- Handshake: cmd_fire = cmd_valid & cmd_ready; rsp_fire = rsp_valid & rsp_ready.
- RAM drive is combinational from the command port:
  - mem_addr = cmd_addr.
  - mem_din = cmd_wdata.
  - mem_we = cmd_fire & cmd_write.
  - mem_addr is don't-care when there is no fire; the RAM still performs a harmless read.
- Credits:
  - outstanding = occupancy + rd_pend.
  - cmd_ready = nreset & (outstanding < DEPTH).
  - cmd_ready is registered-state only: no combinational path from rsp_ready or cmd_valid.
  - cmd_ready gates writes too, so command order is preserved.
- Read issue: a read cmd_fire in cycle t sets rd_pend=1 at edge t+1.
- Capture:
  - In the cycle where rd_pend=1, mem_dout is written into the FIFO at that cycle's closing edge.
  - rd_pend clears unless a new read fires in the same cycle.
- Read latency: cmd_fire (read) in cycle t gives rsp_valid in cycle t+2 at the earliest, if the FIFO was empty.
- Writes produce no response. A write at cycle t followed by a read of the same address at t+1 returns the new data.
- FIFO:
  - rsp_rdata = mem[rd_ptr]; rsp_valid = occupancy != 0.
  - A simultaneous push and pop leaves occupancy unchanged.
  - Pointers wrap modulo DEPTH; occupancy is held in a counter of width clog2(DEPTH)+1.
- Overflow is impossible by construction (credit rule). No pop occurs when the FIFO is empty.
- rsp_valid is held, and rsp_rdata is held stable, until rsp_fire.
- Throughput:
  - Writes: 1 per cycle while credits are available.
  - Reads: 1 per cycle with rsp_ready held high and DEPTH>=3.

Test Plan:
- Reset, then write addr 5 = 0xBEEF; read addr 5 at the next cycle with rsp_ready=1 -> rsp_valid 2 cycles after the read fire, rsp_rdata=0xBEEF; mem_we high for exactly 1 cycle.
- Back-to-back reads of addrs 0..7 (preloaded with value = addr*3), rsp_ready=1, DEPTH=4 -> cmd_ready stays 1; responses 0,3,..,21 on consecutive cycles in order.
- Hold rsp_ready=0 and issue 6 reads -> exactly 4 accepted, then cmd_ready=0. Release rsp_ready -> 4 responses in order, then the remaining 2 are accepted.
- Alternate write/read of the same address (W a=9 d=1, R 9, W 9 d=2, R 9) -> responses 1 then 2.
- Pull nreset low the cycle after a read fire with 2 entries buffered -> rsp_valid=0 immediately; after reset release no stale response appears and cmd_ready=1.
- Random valid/ready toggling, 1000 commands, checked against a reference memory model -> all read data match, no drops or duplicates, occupancy never exceeds DEPTH.
